// File: rtl/dispatch_queue.sv
// In-order 2-wide instruction buffer between decode and dispatch: accepts up to two
// entries per cycle, presents the two oldest, and retires 0-2 per cycle on issue.
module dispatch_queue #(
  parameter int DEPTH       = 8,
  parameter int ENTRY_WIDTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         pause,
  input  logic [1:0]                   enq_valid,
  input  logic [2*ENTRY_WIDTH-1:0]     enq_data,
  output logic                         enq_ready,
  output logic [1:0]                   deq_valid,
  output logic [2*ENTRY_WIDTH-1:0]     deq_data,
  input  logic [1:0]                   issue_en,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: an enqueue is taken only in a cycle where enq_ready is high (and no flush);
  // enq_ready depends on registered occupancy alone, so the decoder never sees a
  // combinational path back from dispatch. deq_valid[i] qualifies deq_data slot i, and
  // issue_en[i] retires slot i only when that slot is valid and the pipe is not paused.
  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]          head_q, tail_q;
  logic [CW-1:0]          count_q;
  logic [PW-1:0]          head_p1, tail_p1;
  logic                   enq_accept;
  logic [1:0]             push_n, pop_req, pop_n;
  logic [ENTRY_WIDTH-1:0] slot0_in, slot1_in;

  assign slot0_in  = enq_data[0 +: ENTRY_WIDTH];
  assign slot1_in  = enq_data[ENTRY_WIDTH +: ENTRY_WIDTH];
  assign head_p1   = head_q + PW'(1);
  assign tail_p1   = tail_q + PW'(1);

  assign enq_ready  = (count_q <= CW'(DEPTH - 2));
  assign enq_accept = enq_ready && !flush;
  assign count      = count_q;

  always_comb begin
    push_n = 2'd0;
    if (enq_accept) begin
      case (enq_valid)
        2'b01, 2'b10: push_n = 2'd1;
        2'b11:        push_n = 2'd2;
        default:      push_n = 2'd0;
      endcase
    end
  end

  // Only 11 and 01 retire; a lone slot-1 issue cannot skip over slot 0.
  always_comb begin
    pop_req = 2'd0;
    case (issue_en)
      2'b11:   pop_req = 2'd2;
      2'b01:   pop_req = 2'd1;
      default: pop_req = 2'd0;
    endcase
  end

  always_comb begin
    pop_n = 2'd0;
    if (!pause && !flush) begin
      if (count_q < CW'(pop_req)) pop_n = count_q[1:0];
      else                        pop_n = pop_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(pop_n);
      tail_q  <= tail_q + PW'(push_n);
      count_q <= count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && enq_accept) begin
      case (enq_valid)
        2'b01: mem[tail_q] <= slot0_in;
        2'b10: mem[tail_q] <= slot1_in;
        2'b11: begin
          mem[tail_q]  <= slot0_in;
          mem[tail_p1] <= slot1_in;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    deq_valid[0] = (count_q >= CW'(1));
    deq_valid[1] = (count_q >= CW'(2));
    deq_data     = '0;
    if (deq_valid[0]) deq_data[0 +: ENTRY_WIDTH]           = mem[head_q];
    if (deq_valid[1]) deq_data[ENTRY_WIDTH +: ENTRY_WIDTH] = mem[head_p1];
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed driver, queue-based scoreboard checked every cycle by
// a monitor, plus hand-computed occupancy checks at the interesting points.
module tb_dispatch_queue;

  localparam int DEPTH = 8;
  localparam int EW    = 256;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            pause;
  logic [1:0]      enq_valid;
  logic [2*EW-1:0] enq_data;
  logic            enq_ready;
  logic [1:0]      deq_valid;
  logic [2*EW-1:0] deq_data;
  logic [1:0]      issue_en;
  logic [3:0]      count;

  logic            exp_accept;
  logic [EW-1:0]   exp_q[$];
  int              n_cmp;
  int              n_err;

  dispatch_queue #(.DEPTH(DEPTH), .ENTRY_WIDTH(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .pause     (pause),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .issue_en  (issue_en),
    .count     (count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] mk(input int k);
    return {8{32'hD000_0000 | 32'(k)}};
  endfunction

  task automatic cmp(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Driver: one call = one cycle of inputs, applied just after the rising edge.
  task automatic drive(input logic [1:0] ev, input int k0, input int k1, input logic acc,
                       input logic [1:0] ie, input logic p, input logic f);
    @(posedge clk);
    #1;
    enq_valid  = ev;
    enq_data   = {mk(k1), mk(k0)};
    exp_accept = acc;
    issue_en   = ie;
    pause      = p;
    flush      = f;
  endtask

  task automatic idle();
    drive(2'b00, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic expect_count(input string name, input int exp_cnt);
    @(negedge clk);
    cmp(name, EW'(count), EW'(exp_cnt));
  endtask

  // Monitor / scoreboard: compare the dequeue view with the model, then apply this cycle.
  always @(negedge clk) begin
    int sz;
    int n;
    if (rst) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      cmp("deq_valid", EW'(deq_valid), EW'({sz > 1, sz > 0}));
      cmp("deq_slot0", deq_data[0 +: EW], (sz > 0) ? exp_q[0] : '0);
      cmp("deq_slot1", deq_data[EW +: EW], (sz > 1) ? exp_q[1] : '0);
      cmp("count_model", EW'(count), EW'(sz));
      cmp("enq_ready_model", EW'(enq_ready), EW'(DEPTH - sz >= 2));
      if (flush) begin
        exp_q.delete();
      end else begin
        if (!pause) begin
          n = (issue_en == 2'b11) ? 2 : (issue_en == 2'b01) ? 1 : 0;
          if (n > sz) n = sz;
          repeat (n) void'(exp_q.pop_front());
        end
        if (exp_accept) begin
          if (enq_valid[0]) exp_q.push_back(enq_data[0 +: EW]);
          if (enq_valid[1]) exp_q.push_back(enq_data[EW +: EW]);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; flush = 1'b0; pause = 1'b0; enq_valid = 2'b00;
    enq_data = '0; issue_en = 2'b00; exp_accept = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    cmp("rst_count", EW'(count), EW'(0));
    cmp("rst_ready", EW'(enq_ready), EW'(1));
    cmp("rst_deq_valid", EW'(deq_valid), EW'(0));
    cmp("rst_deq_data", deq_data[0 +: EW] | deq_data[EW +: EW], '0);

    // A,B then retire A
    drive(2'b11, 1, 2, 1'b1, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 0, 0, 1'b0, 2'b01, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    cmp("ab_count", EW'(count), EW'(1));
    cmp("ab_valid", EW'(deq_valid), EW'(2'b01));
    cmp("ab_slot0_b", deq_data[0 +: EW], mk(2));

    // Retire B, enqueue C on slot 1 only, then over-issue
    drive(2'b00, 0, 0, 1'b0, 2'b01, 1'b0, 1'b0);
    drive(2'b10, 99, 3, 1'b1, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 0, 0, 1'b0, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    cmp("c_count", EW'(count), EW'(1));
    cmp("c_slot0", deq_data[0 +: EW], mk(3));
    idle();
    expect_count("clamp_count", 0);

    // Fill to DEPTH, overfill, pause, full with retire
    for (int k = 0; k < 4; k++) drive(2'b11, 10 + 2*k, 11 + 2*k, 1'b1, 2'b00, 1'b0, 1'b0);
    drive(2'b11, 90, 91, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    cmp("full_count", EW'(count), EW'(8));
    cmp("full_ready", EW'(enq_ready), EW'(0));
    drive(2'b11, 92, 93, 1'b0, 2'b11, 1'b1, 1'b0);
    expect_count("overfill_count", 8);
    drive(2'b00, 0, 0, 1'b0, 2'b11, 1'b1, 1'b0);
    expect_count("pause_count", 8);
    drive(2'b11, 94, 95, 1'b0, 2'b11, 1'b0, 1'b0);
    expect_count("pause2_count", 8);
    cmp("pause_slot0", deq_data[0 +: EW], mk(10));
    idle();
    expect_count("full_pop_count", 6);
    repeat (3) drive(2'b00, 0, 0, 1'b0, 2'b11, 1'b0, 1'b0);
    idle();
    expect_count("drain_count", 0);

    // Steady stream across pointer wrap
    for (int k = 0; k < 10; k++) drive(2'b11, 30 + 2*k, 31 + 2*k, 1'b1, 2'b11, 1'b0, 1'b0);
    idle();
    expect_count("wrap_count", 2);
    cmp("wrap_slot0", deq_data[0 +: EW], mk(48));
    cmp("wrap_slot1", deq_data[EW +: EW], mk(49));
    drive(2'b00, 0, 0, 1'b0, 2'b11, 1'b0, 1'b0);
    idle();

    // Flush with simultaneous enqueue and issue
    drive(2'b11, 60, 61, 1'b1, 2'b00, 1'b0, 1'b0);
    drive(2'b11, 62, 63, 1'b1, 2'b00, 1'b0, 1'b0);
    drive(2'b01, 64, 0, 1'b1, 2'b00, 1'b0, 1'b0);
    drive(2'b11, 65, 66, 1'b0, 2'b11, 1'b0, 1'b1);
    expect_count("preflush_count", 5);
    idle();
    expect_count("flush_count", 0);
    cmp("flush_valid", EW'(deq_valid), EW'(0));

    // Normal operation after flush
    drive(2'b11, 70, 71, 1'b1, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 0, 0, 1'b0, 2'b11, 1'b0, 1'b0);
    idle();
    expect_count("post_flush_count", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
